// File: rtl/flt_pkg.sv
// rtl/flt_pkg.sv - shared types and constants for the sequential float add/sub
package flt_pkg;

   localparam int DEF_EXP_W = 5;
   localparam int DEF_MAN_W = 10;
   localparam int GRS_W     = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SWAP,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_t;

   function automatic int sign_bit(input int exp_w, input int man_w);
      return exp_w + man_w;
   endfunction

   function automatic int exp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/flt_round_unit.sv
// rtl/flt_round_unit.sv - mantissa rounding; nearest-even with FLT_ROUND_NEAREST_EN, else truncate
module flt_round_unit import flt_pkg::*; #(
   parameter int EXP_W = DEF_EXP_W,
   parameter int MAN_W = DEF_MAN_W
) (
   input  logic        [MAN_W+GRS_W:0] man_i,
   input  logic signed [EXP_W+1:0]     exp_i,
   output logic        [MAN_W-1:0]     frac_o,
   output logic signed [EXP_W+1:0]     exp_o
);
   localparam int EW = EXP_W + 2;

`ifdef FLT_ROUND_NEAREST_EN
   logic             inc;
   logic [MAN_W+1:0] rnd;

   // man_i[3] is the result lsb, [2] guard, [1] round, [0] sticky
   always_comb begin
      inc = man_i[2] & (man_i[1] | man_i[0] | man_i[3]);
      rnd = {1'b0, man_i[MAN_W+GRS_W:GRS_W]} + {{(MAN_W+1){1'b0}}, inc};
      if (rnd[MAN_W+1]) begin
         frac_o = '0;
         exp_o  = exp_i + EW'(1);
      end else begin
         frac_o = rnd[MAN_W-1:0];
         exp_o  = exp_i;
      end
   end
`else
   logic unused_bits;

   assign unused_bits = ^{man_i[MAN_W+GRS_W], man_i[GRS_W-1:0]};
   assign frac_o      = man_i[MAN_W+GRS_W-1:GRS_W];
   assign exp_o       = exp_i;
`endif

endmodule

// File: rtl/flt_addsub_seq.sv
// rtl/flt_addsub_seq.sv - multi-cycle float add/sub FSM; FLT_ROUND_NEAREST_EN selects rounding mode
module flt_addsub_seq import flt_pkg::*; #(
   parameter int EXP_W = DEF_EXP_W,
   parameter int MAN_W = DEF_MAN_W
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [EXP_W+MAN_W:0] OpA,
   input  logic [EXP_W+MAN_W:0] OpB,
   input  logic                 Sub,
   output logic [EXP_W+MAN_W:0] Result,
   output logic                 Done,
   output logic                 Busy,
   output logic                 Overflow,
   output logic                 Zero
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int SGN = sign_bit(EXP_W, MAN_W);
   localparam int X   = MAN_W + 1 + GRS_W;
   localparam int EW  = EXP_W + 2;
   localparam logic [EXP_W-1:0]        EXP_ONES = '1;
   localparam logic [EXP_W-1:0]        GAP_MAX  = EXP_W'(MAN_W + GRS_W);
   localparam logic signed [EW-1:0]    EXP_MIN  = EW'(1);
   localparam logic signed [EW-1:0]    EXP_TOP  = $signed({2'b00, EXP_ONES});

   state_t             state_q;
   logic [W-1:0]       a_q, b_q, result_q;
   logic               sub_q, sign_q, eff_sub_q, special_q, zero_q;
   logic               done_q, busy_q, ovf_q, zro_q;
   logic signed [EW-1:0] exp_q;
   logic [EXP_W-1:0]   diff_q;
   logic [X-1:0]       ref_q, sml_q;
   logic [X:0]         sum_q;

   logic [EXP_W-1:0]   ea, eb;
   logic               a_zero, b_zero, a_inf, b_inf, a_ge_b, sb_eff;
   logic [W-2:0]       mag_a, mag_b;
   logic [X-1:0]       man_a, man_b;
   logic [MAN_W-1:0]   rnd_frac_d;
   logic signed [EW-1:0] rnd_exp_d;

   // Exponent-0 operands are flushed to zero before comparison and alignment
   always_comb begin
      ea     = a_q[W-2:MAN_W];
      eb     = b_q[W-2:MAN_W];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (ea == EXP_ONES);
      b_inf  = (eb == EXP_ONES);
      mag_a  = a_zero ? '0 : a_q[W-2:0];
      mag_b  = b_zero ? '0 : b_q[W-2:0];
      man_a  = a_zero ? '0 : {1'b1, a_q[MAN_W-1:0], {GRS_W{1'b0}}};
      man_b  = b_zero ? '0 : {1'b1, b_q[MAN_W-1:0], {GRS_W{1'b0}}};
      a_ge_b = (mag_a >= mag_b);
      sb_eff = b_q[SGN] ^ sub_q;
   end

   flt_round_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
      .man_i  (sum_q[X-1:0]),
      .exp_i  (exp_q),
      .frac_o (rnd_frac_d),
      .exp_o  (rnd_exp_d)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zro_q    <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (Start) begin
                  a_q     <= OpA;
                  b_q     <= OpB;
                  sub_q   <= Sub;
                  done_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_SWAP;
               end
            end
            S_SWAP: begin
               special_q <= a_inf | b_inf;
               zero_q    <= 1'b0;
               eff_sub_q <= a_q[SGN] ^ sb_eff;
               if (a_ge_b) begin
                  ref_q  <= man_a;
                  sml_q  <= man_b;
                  exp_q  <= $signed({2'b00, ea});
                  diff_q <= ea - eb;
                  sign_q <= a_q[SGN];
               end else begin
                  ref_q  <= man_b;
                  sml_q  <= man_a;
                  exp_q  <= $signed({2'b00, eb});
                  diff_q <= eb - ea;
                  sign_q <= sb_eff;
               end
               if (a_inf)
                  sign_q <= a_q[SGN];
               else if (b_inf)
                  sign_q <= sb_eff;
               state_q <= S_ALIGN;
            end
            S_ALIGN: begin
               if (diff_q == '0) begin
                  state_q <= S_ADD;
               end else if (diff_q > GAP_MAX) begin
                  sml_q   <= {{(X-1){1'b0}}, |sml_q};
                  diff_q  <= '0;
                  state_q <= S_ADD;
               end else begin
                  sml_q  <= {1'b0, sml_q[X-1:2], |sml_q[1:0]};
                  diff_q <= diff_q - 1'b1;
               end
            end
            S_ADD: begin
               sum_q   <= eff_sub_q ? {1'b0, ref_q} - {1'b0, sml_q}
                                    : {1'b0, ref_q} + {1'b0, sml_q};
               state_q <= S_NORM;
            end
            S_NORM: begin
               if (sum_q == '0) begin
                  zero_q  <= 1'b1;
                  state_q <= S_ROUND;
               end else if (sum_q[X]) begin
                  sum_q   <= {1'b0, sum_q[X:2], |sum_q[1:0]};
                  exp_q   <= exp_q + EW'(1);
                  state_q <= S_ROUND;
               end else if (sum_q[X-1]) begin
                  state_q <= S_ROUND;
               end else begin
                  sum_q <= {sum_q[X-1:0], 1'b0};
                  exp_q <= exp_q - EW'(1);
               end
            end
            S_ROUND: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_DONE;
               if (special_q) begin
                  result_q <= {sign_q, EXP_ONES, {MAN_W{1'b0}}};
                  ovf_q    <= 1'b1;
                  zro_q    <= 1'b0;
               end else if (zero_q || rnd_exp_d < EXP_MIN) begin
                  result_q <= '0;
                  ovf_q    <= 1'b0;
                  zro_q    <= 1'b1;
               end else if (rnd_exp_d >= EXP_TOP) begin
                  result_q <= {sign_q, EXP_ONES, {MAN_W{1'b0}}};
                  ovf_q    <= 1'b1;
                  zro_q    <= 1'b0;
               end else begin
                  result_q <= {sign_q, rnd_exp_d[EXP_W-1:0], rnd_frac_d};
                  ovf_q    <= 1'b0;
                  zro_q    <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign Result   = result_q;
   assign Done     = done_q;
   assign Busy     = busy_q;
   assign Overflow = ovf_q;
   assign Zero     = zro_q;

endmodule

// File: tb/tb_flt_addsub_seq.sv
// tb/tb_flt_addsub_seq.sv - vector table plus scoreboard bench for flt_addsub_seq
module tb_flt_addsub_seq;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] res;
      logic        ovf;
      logic        zro;
   } vec_t;

   localparam int MAX_LAT = 2 * 10 + 10;
`ifdef FLT_ROUND_NEAREST_EN
   localparam logic [15:0] RND_RES = 16'h3C02;
`else
   localparam logic [15:0] RND_RES = 16'h3C01;
`endif

   logic        Clk = 1'b0;
   logic        Reset, Start, Sub;
   logic [15:0] OpA, OpB, Result;
   logic        Done, Busy, Overflow, Zero;

   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[15];
   vec_t sb[$];

   flt_addsub_seq dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .OpA      (OpA),
      .OpB      (OpB),
      .Sub      (Sub),
      .Result   (Result),
      .Done     (Done),
      .Busy     (Busy),
      .Overflow (Overflow),
      .Zero     (Zero)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v);
      int   cyc;
      logic seen;
      vec_t e;
      sb.push_back(v);
      OpA   = v.a;
      OpB   = v.b;
      Sub   = v.sub;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      OpA   = 16'($urandom);
      OpB   = 16'($urandom);
      Sub   = ~Sub;
      check("busy_after_start", {31'd0, Busy}, 32'd1);
      check("done_cleared", {31'd0, Done}, 32'd0);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(posedge Clk); #1;
         cyc++;
         if (Done) seen = 1'b1;
      end
      check("done_seen", {31'd0, seen}, 32'd1);
      n_checks++;
      if (cyc < 5 || cyc > MAX_LAT) begin
         n_fail++;
         $display("FAIL latency %h+%h: got %0d cycles required 5..%0d", v.a, v.b, cyc, MAX_LAT);
      end
      e = sb.pop_front();
      check($sformatf("result %h%s%h", e.a, e.sub ? "-" : "+", e.b), {16'd0, Result}, {16'd0, e.res});
      check($sformatf("overflow %h/%h", e.a, e.b), {31'd0, Overflow}, {31'd0, e.ovf});
      check($sformatf("zero %h/%h", e.a, e.b), {31'd0, Zero}, {31'd0, e.zro});
      check("busy_in_done", {31'd0, Busy}, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0};
      vecs[1]  = '{16'h4000, 16'h4200, 1'b1, 16'hBC00, 1'b0, 1'b0};
      vecs[2]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b1};
      vecs[3]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0};
      vecs[4]  = '{16'h3C01, 16'h1000, 1'b0, RND_RES,  1'b0, 1'b0};
      vecs[5]  = '{16'h3C00, 16'h0400, 1'b0, 16'h3C00, 1'b0, 1'b0};
      vecs[6]  = '{16'h3C00, 16'h4000, 1'b0, 16'h4200, 1'b0, 1'b0};
      vecs[7]  = '{16'hC000, 16'h3C00, 1'b0, 16'hBC00, 1'b0, 1'b0};
      vecs[8]  = '{16'h0000, 16'h3C00, 1'b0, 16'h3C00, 1'b0, 1'b0};
      vecs[9]  = '{16'h0200, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
      vecs[10] = '{16'h0401, 16'h0400, 1'b1, 16'h0000, 1'b0, 1'b1};
      vecs[11] = '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 1'b1, 1'b0};
      vecs[12] = '{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 1'b1, 1'b0};
      vecs[13] = '{16'h5640, 16'h3C00, 1'b0, 16'h5650, 1'b0, 1'b0};
      vecs[14] = '{16'h3C00, 16'hBC00, 1'b0, 16'h0000, 1'b0, 1'b1};

      // Reset with Start held high must leave the block idle
      Reset = 1'b1;
      Start = 1'b1;
      OpA   = 16'h3C00;
      OpB   = 16'h3C00;
      Sub   = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      check("reset_result", {16'd0, Result}, 32'd0);
      check("reset_flags", {28'd0, Done, Busy, Overflow, Zero}, 32'd0);
      Reset = 1'b0;
      Start = 1'b0;
      @(posedge Clk); #1;
      check("idle_after_reset", {30'd0, Busy, Done}, 32'd0);

      for (int i = 0; i < 15; i++)
         run_op(vecs[i]);

      // DONE holds its outputs while Start stays low
      run_op('{16'h3C00, 16'h4000, 1'b0, 16'h4200, 1'b0, 1'b0});
      repeat (3) begin
         OpA = 16'($urandom);
         OpB = 16'($urandom);
         @(posedge Clk); #1;
      end
      check("hold_result", {16'd0, Result}, 32'h4200);
      check("hold_done", {31'd0, Done}, 32'd1);

      // Reset in the middle of a long alignment
      OpA   = 16'h3C01;
      OpB   = 16'h1000;
      Sub   = 1'b0;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check("busy_mid_align", {31'd0, Busy}, 32'd1);
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
      check("midreset_result", {16'd0, Result}, 32'd0);
      check("midreset_flags", {28'd0, Done, Busy, Overflow, Zero}, 32'd0);
      run_op('{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
